// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction speed tester: FSM state codes, LFSR constants, tick rate.
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_MEASURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps at bits 15, 13, 12 and 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned TICK_HZ = 10000;

endpackage

// File: rtl/reaction_if.sv
// Button/tick inputs and result/status outputs of the reaction controller.
interface reaction_if #(
   parameter int unsigned RESULT_W = 14
) ();

   logic                tick;
   logic                start;
   logic                react;
   logic                stimulus_led;
   logic [RESULT_W-1:0] result;
   logic                result_valid;
   logic                early;
   logic                timeout;
   logic                busy;
   logic [2:0]          state;

   modport master (
      output tick, start, react,
      input  stimulus_led, result, result_valid, early, timeout, busy, state
   );

   modport slave (
      input  tick, start, react,
      output stimulus_led, result, result_valid, early, timeout, busy, state
   );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every clock.
module lfsr16
   import reaction_pkg::*;
(
   input  logic        sysclk,
   input  logic        reset,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reaction_controller.sv
// Reaction tester sequencer: arms on start, waits a random number of ticks, lights the LED,
// then measures ticks until react, reporting result, early press or timeout.
module reaction_controller
   import reaction_pkg::*;
#(
   parameter int unsigned MIN_WAIT_TICKS = 10000,
   parameter int unsigned RAND_WAIT_BITS = 14,
   parameter int unsigned TIMEOUT_TICKS  = 9999,
   parameter int unsigned RESULT_W       = 14
) (
   input logic       sysclk,
   input logic       reset,
   reaction_if.slave bus
);

   localparam logic [15:0]         MinWait  = 16'(MIN_WAIT_TICKS);
   localparam logic [RESULT_W-1:0] TimeoutV = RESULT_W'(TIMEOUT_TICKS);
   localparam logic [RESULT_W-1:0] LastCnt  = RESULT_W'(TIMEOUT_TICKS - 1);

   state_e              state_q, state_d;
   logic [15:0]         wait_cnt_q, wait_cnt_d;
   logic [RESULT_W-1:0] react_cnt_q, react_cnt_d;
   logic [RESULT_W-1:0] result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic                early_q, early_d;
   logic                timeout_q, timeout_d;
   logic                led_q, led_d;
   logic                start_q, react_q;
   logic                start_rise, react_rise;
   logic [15:0]         lfsr;
   logic                unused_lfsr;

   lfsr16 u_lfsr (
      .sysclk (sysclk),
      .reset  (reset),
      .q      (lfsr)
   );

   // Only the low RAND_WAIT_BITS of the generator feed the wait.
   assign unused_lfsr = ^lfsr;

   assign start_rise = bus.start & ~start_q;
   assign react_rise = bus.react & ~react_q;

   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      react_cnt_d    = react_cnt_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      early_d        = early_q;
      timeout_d      = timeout_q;
      led_d          = led_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               result_d       = '0;
               result_valid_d = 1'b0;
               early_d        = 1'b0;
               timeout_d      = 1'b0;
               state_d        = ST_LOAD;
            end
         end
         ST_LOAD: begin
            wait_cnt_d = MinWait + 16'(lfsr[RAND_WAIT_BITS-1:0]);
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A react press beats the expiry tick in the same cycle.
            if (react_rise) begin
               early_d  = 1'b1;
               result_d = '0;
               state_d  = ST_DONE;
            end else if (bus.tick) begin
               if (wait_cnt_q == 16'd1) begin
                  react_cnt_d = '0;
                  led_d       = 1'b1;
                  state_d     = ST_MEASURE;
               end else begin
                  wait_cnt_d = wait_cnt_q - 16'd1;
               end
            end
         end
         ST_MEASURE: begin
            if (react_rise) begin
               result_d       = react_cnt_q;
               result_valid_d = 1'b1;
               led_d          = 1'b0;
               state_d        = ST_DONE;
            end else if (bus.tick) begin
               if (react_cnt_q == LastCnt) begin
                  result_d  = TimeoutV;
                  timeout_d = 1'b1;
                  led_d     = 1'b0;
                  state_d   = ST_DONE;
               end else begin
                  react_cnt_d = react_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            led_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Edge registers reset high so a button held through reset never triggers.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         wait_cnt_q     <= '0;
         react_cnt_q    <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         early_q        <= 1'b0;
         timeout_q      <= 1'b0;
         led_q          <= 1'b0;
         start_q        <= 1'b1;
         react_q        <= 1'b1;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         react_cnt_q    <= react_cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         early_q        <= early_d;
         timeout_q      <= timeout_d;
         led_q          <= led_d;
         start_q        <= bus.start;
         react_q        <= bus.react;
      end
   end

   assign bus.stimulus_led = led_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.early        = early_q;
   assign bus.timeout      = timeout_q;
   assign bus.state        = state_q;
   assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_WAIT) ||
                             (state_q == ST_MEASURE);

endmodule

// File: doc/reaction_controller.md
# reaction_controller

Sequencing FSM for the reaction speed tester. It runs off the 10 kHz tick from the clock divider and arms a trial on a start press. After a pseudo-random wait it lights the stimulus LED, then counts 0.1 ms ticks until the react press. The resulting reaction time, early-press flag or timeout flag goes to the display/scoreboard logic downstream.

## Interface
- MIN_WAIT_TICKS, 10000: minimum wait before stimulus, in ticks (≥1).
- RAND_WAIT_BITS, 14: width of random extra wait; extra wait is 0..2^RAND_WAIT_BITS−1 ticks.
- TIMEOUT_TICKS, 9999: maximum measurable reaction, in ticks.
- RESULT_W, 14: result width; must hold TIMEOUT_TICKS.
- Constraint: MIN_WAIT_TICKS + 2^RAND_WAIT_BITS − 1 < 2^16.

Ports:
- sysclk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-sysclk-wide enable at 10 kHz, derived from the divided clock.
- start  in  1  debounced start button level.
- react  in  1  debounced reaction button level.
- stimulus_led  out  1  stimulus light.
- result  out  RESULT_W  reaction time in ticks.
- result_valid  out  1  a valid measurement is held in result.
- early  out  1  react was pressed before the stimulus.
- timeout  out  1  no react within TIMEOUT_TICKS.
- busy  out  1  a trial is in progress.
- state  out  3  FSM state code, for debug and display.

## Operation
- Edge detect: start_rise = start & ~start_q, react_rise = react & ~react_q. start_q and react_q reset to 1, so a button held through reset never triggers.
- LFSR: 16-bit Fibonacci, fb = q[15]^q[13]^q[12]^q[10], q <= {q[14:0],fb}. Seed 16'hACE1 on reset. Advances every sysclk regardless of state.
- States and codes: IDLE=0, LOAD=1, WAIT=2, MEASURE=3, DONE=4. Codes 5–7 are illegal and go to IDLE.
- IDLE: on start_rise, clear result, result_valid, early and timeout, then go to LOAD.
- LOAD (one cycle): wait_cnt <= MIN_WAIT_TICKS + lfsr[RAND_WAIT_BITS-1:0] (16-bit, zero-extended), then go to WAIT.
- WAIT:
  - On react_rise: early=1, result=0, go to DONE. This has priority over tick.
  - Else on tick with wait_cnt==1: react_cnt=0, stimulus_led=1, go to MEASURE.
  - Else on tick: wait_cnt−1.
  - Net effect: exactly MIN+rand ticks in WAIT.
- MEASURE:
  - On react_rise: result=react_cnt, result_valid=1, led=0, go to DONE. This has priority over tick; the count is the pre-increment value.
  - Else on tick with react_cnt==TIMEOUT_TICKS−1: result=TIMEOUT_TICKS, timeout=1, led=0, go to DONE.
  - Else on tick: react_cnt+1.
- DONE: holds all outputs. On start_rise, clear the flags and result, then go to LOAD.
- start_rise is ignored in LOAD, WAIT and MEASURE. react_rise is ignored in IDLE, LOAD and DONE.
- busy = state ∈ {LOAD, WAIT, MEASURE}. stimulus_led = 1 only in MEASURE.

## Timing
- Reset values:
  - Outputs: state=IDLE(0), stimulus_led=0, result=0, result_valid=0, early=0, timeout=0, busy=0.
  - Internal: wait_cnt=0, react_cnt=0, lfsr=16'hACE1.
- Reset mid-trial: all of the above take effect immediately (asynchronous), including the LED turning off.
- All outputs are registered. A qualifying edge seen at sysclk edge N is visible after edge N (1-cycle latency).
- Delays:
  - start_rise to WAIT: 2 cycles.
  - Stimulus to MEASURE: the LED rises after the tick that ends the wait.
- Resolution is 1 tick (0.1 ms). Maximum valid result is TIMEOUT_TICKS−1. The counters never wrap.

## Structure
- Shared package/header reaction_pkg holds:
  - State codes ST_IDLE..ST_DONE.
  - LFSR seed 16'hACE1 and tap constants.
  - Tick rate constant TICK_HZ=10000.
- Sub-module lfsr16 (sysclk, reset, q[15:0]): free-running generator, reusable by other experiments.
- The FSM and both counters stay in reaction_controller.

## Test plan
Simulation uses MIN_WAIT_TICKS=4, RAND_WAIT_BITS=2, TIMEOUT_TICKS=20, and tick every 4 sysclk.
- Reset: assert reset with start held high. Required: all outputs 0, state=0. No trial starts after release until start falls and rises again.
- Normal trial: start pulse, then react pressed on the 7th tick after the LED rises. Required: result=7, result_valid=1, LED 0, state=4. WAIT length equals 4 + lfsr[1:0] ticks, checked against a reference model.
- Early press: react during WAIT. Required: early=1, result=0, result_valid=0, the LED never rises, state=4.
- Timeout: no react. Required: after 20 ticks in MEASURE, timeout=1, result=20, result_valid=0, LED 0.
- Simultaneous: react_rise in the same cycle as a tick while react_cnt=5. Required: result=5. Also, react_rise together with the expiry tick in WAIT gives early=1.
- Reset mid-MEASURE, plus restart from DONE:
  - Reset in MEASURE: LED drops immediately and state=0.
  - start_rise in DONE clears the flags and returns to LOAD next cycle.
